// File: rtl/imem_responder.sv
// Instruction-memory responder: pipelined synchronous array read feeding a
// fall-through response FIFO, with credit-based request flow control and flush.
module imem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]           r_mem     [WORDS];
  logic                  r_rst_done;
  logic [CW-1:0]         r_credits;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_s_valid [LATENCY];
  logic [31:0]           r_s_addr  [LATENCY];
  logic                  r_s_err   [LATENCY];
  logic [31:0]           r_s_data  [LATENCY];
  logic [31:0]           r_f_addr  [FIFO_DEPTH];
  logic [31:0]           r_f_data  [FIFO_DEPTH];
  logic                  r_f_err   [FIFO_DEPTH];

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_req_err;
  logic                  w_load_err;
  logic [DEPTH_LOG2-1:0] w_req_idx;
  logic [DEPTH_LOG2-1:0] w_load_idx;

  // Misaligned or beyond the array: never aliased onto a real word.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_req_err  = addr_bad(req_addr);
  assign w_load_err = addr_bad(load_addr);
  assign w_req_idx  = req_addr[DEPTH_LOG2+1:2];
  assign w_load_idx = load_addr[DEPTH_LOG2+1:2];

  assign req_ready = r_rst_done & ~flush & (r_credits < CW'(FIFO_DEPTH));
  assign rsp_valid = (r_count != '0);
  assign w_accept  = req_valid & req_ready;
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_push    = r_s_valid[LATENCY-1];

  assign rsp_instr = rsp_valid ? r_f_data[r_rd_ptr] : 32'd0;
  assign rsp_addr  = rsp_valid ? r_f_addr[r_rd_ptr] : 32'd0;
  assign rsp_err   = rsp_valid & r_f_err[r_rd_ptr];

  // Control state: stage valids, FIFO pointers/occupancy, credits.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      r_rst_done <= 1'b0;
      r_credits  <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_s_valid[i] <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (flush) begin
        r_credits <= '0;
        r_count   <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        for (int unsigned i = 0; i < LATENCY; i++) r_s_valid[i] <= 1'b0;
      end else begin
        r_s_valid[0] <= w_accept;
        for (int unsigned i = 1; i < LATENCY; i++) r_s_valid[i] <= r_s_valid[i-1];
        if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
        r_count   <= r_count + CW'(w_push) - CW'(w_pop);
        r_credits <= r_credits + CW'(w_accept) - CW'(w_pop);
      end
    end
  end

  // Datapath storage, not reset; array read is read-first against a same-edge load.
  always_ff @(posedge reloj) begin
    if (load_we && !w_load_err) r_mem[w_load_idx] <= load_data;
    r_s_addr[0] <= req_addr;
    r_s_err[0]  <= w_req_err;
    r_s_data[0] <= w_req_err ? 32'd0 : r_mem[w_req_idx];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      r_s_addr[i] <= r_s_addr[i-1];
      r_s_err[i]  <= r_s_err[i-1];
      r_s_data[i] <= r_s_data[i-1];
    end
    if (w_push) begin
      r_f_addr[r_wr_ptr] <= r_s_addr[LATENCY-1];
      r_f_data[r_wr_ptr] <= r_s_data[LATENCY-1];
      r_f_err[r_wr_ptr]  <= r_s_err[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed table, corner sequences and
// randomized traffic against a queue-based transaction model.
module tb_imem_responder;

  localparam int unsigned DL  = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;

  logic        reloj = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  imem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .reloj(reloj), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 reloj = ~reloj;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          t;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] instr;
  } vec_t;

  ent_t        q[$];
  logic [31:0] mmem [2**DL];
  bit          m_rst_done = 1'b0;
  bit          last_acc;
  int          cyc = 0;
  int          n_err = 0;
  int          n_chk = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DL + 2)) != 32'd0);
  endfunction

  task automatic model_clear();
    q.delete();
    m_rst_done = 1'b0;
  endtask

  // One clock: check outputs at negedge against the model, advance the model at posedge.
  task automatic step();
    bit   e_ready, e_valid, acc, pop;
    ent_t e;
    @(negedge reloj);
    e_ready = m_rst_done && !flush && (q.size() < FD);
    e_valid = (q.size() > 0) && (cyc >= q[0].t);
    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_valid);
    if (e_valid) begin
      chk("rsp_addr", rsp_addr, q[0].addr);
      chk("rsp_err", rsp_err, q[0].err);
      chk("rsp_instr", rsp_instr, q[0].data);
    end
    acc = req_valid && e_ready;
    pop = e_valid && rsp_ready;
    @(posedge reloj);
    cyc++;
    if (!reset) begin
      model_clear();
      acc = 1'b0;
    end else begin
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.addr = req_addr;
          e.err  = bad(req_addr);
          e.data = e.err ? 32'd0 : mmem[req_addr[DL+1:2]];
          e.t    = cyc + LAT;
          q.push_back(e);
        end
      end
      m_rst_done = 1'b1;
    end
    if (load_we && !bad(load_addr)) mmem[load_addr[DL+1:2]] = load_data;
    last_acc = acc;
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    step();
    load_we = 1'b0;
  endtask

  // Single fetch from idle with optional same-edge load to the same address.
  task automatic fetch1(input logic [31:0] a, input bit we, input logic [31:0] wd,
                        input bit e_err, input logic [31:0] e_instr);
    int lat;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    load_we = we; load_addr = a; load_data = wd;
    step();
    chk("fetch_accepted", 32'(last_acc), 32'd1);
    req_valid = 1'b0; load_we = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("fetch_latency", 32'(lat), 32'(LAT));
    chk("fetch_err", 32'(rsp_err), 32'(e_err));
    chk("fetch_instr", rsp_instr, e_instr);
    chk("fetch_addr", rsp_addr, a);
    step();
  endtask

  vec_t vt[11];
  int   n_acc;

  initial begin
    vt[0]  = '{32'h0000_0000, 1'b0, 32'h11};
    vt[1]  = '{32'h0000_0004, 1'b0, 32'h22};
    vt[2]  = '{32'h0000_0008, 1'b0, 32'h33};
    vt[3]  = '{32'h0000_000C, 1'b0, 32'h44};
    vt[4]  = '{32'h0000_0010, 1'b0, 32'h55};
    vt[5]  = '{32'h0000_03FC, 1'b0, 32'hFF};
    vt[6]  = '{32'h0000_0002, 1'b1, 32'h0};
    vt[7]  = '{32'h0000_0400, 1'b1, 32'h0};
    vt[8]  = '{32'h0000_0001, 1'b1, 32'h0};
    vt[9]  = '{32'h8000_0000, 1'b1, 32'h0};
    vt[10] = '{32'hFFFF_FFFC, 1'b1, 32'h0};

    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_instr", rsp_instr, 32'd0);
    chk("reset_rsp_addr", rsp_addr, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("ready_after_release", 32'(req_ready), 32'd1);

    for (int i = 0; i < 2**DL; i++) load(32'(i * 4), $urandom);
    load(32'h0, 32'h11); load(32'h4, 32'h22); load(32'h8, 32'h33);
    load(32'hC, 32'h44); load(32'h10, 32'h55); load(32'h3FC, 32'hFF);
    load(32'h402, 32'hBAD0_BAD0);
    load(32'h800, 32'hBAD1_BAD1);

    for (int i = 0; i < 11; i++) fetch1(vt[i].addr, 1'b0, 32'h0, vt[i].err, vt[i].instr);

    // Back-to-back stream with consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Backpressure: credits cap accepted requests at FIFO depth.
    rsp_ready = 1'b0; n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      step();
      n_acc += int'(last_acc);
    end
    chk("bp_accepted", 32'(n_acc), 32'(FD));
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("bp_ready_back", 32'(req_ready), 32'd1);

    // Flush with three requests in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      step();
    end
    req_valid = 1'b1; flush = 1'b1;
    step();
    chk("flush_no_accept", 32'(last_acc), 32'd0);
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("flush_empty", 32'(rsp_valid), 32'd0);
    fetch1(32'h10, 1'b0, 32'h0, 1'b0, 32'h55);

    // Same-edge load and fetch: old word first, new word on refetch.
    fetch1(32'h8, 1'b1, 32'h0000_DEAD, 1'b0, 32'h33);
    fetch1(32'h8, 1'b0, 32'h0, 1'b0, 32'h0000_DEAD);

    // Asynchronous reset in the middle of a burst.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      step();
    end
    #3 reset = 1'b0;
    #1;
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_reset_req_ready", 32'(req_ready), 32'd0);
    model_clear();
    step();
    reset = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0;
    step();
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       req_addr = $urandom;
        1:       req_addr = 32'h400 + 32'($urandom_range(0, 15) * 4);
        2:       req_addr = 32'($urandom_range(0, 1023));
        default: req_addr = 32'($urandom_range(0, 255) * 4);
      endcase
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      load_we   = ($urandom_range(0, 9) == 0);
      load_addr = ($urandom_range(0, 3) == 0) ? req_addr : 32'($urandom_range(0, 1031));
      load_data = $urandom;
      step();
    end
    req_valid = 1'b0; flush = 1'b0; load_we = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("final_drained", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
